// File: rtl/ssc_reader.sv
// Scanned seven-segment display reader: synchronizes the anode/cathode lines, waits for them
// to settle, decodes each digit's glyph and publishes an 8-digit snapshot per complete frame.
module ssc_reader #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [6:0]  cat_in,
  input  logic [7:0]  an_in,
  input  logic        err_clr_in,
  output logic [31:0] digits_out,
  output logic [7:0]  blank_out,
  output logic [7:0]  invalid_out,
  output logic        frame_valid_out,
  output logic        error_out
);

  localparam int unsigned CntW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntStrobe = CntW'(SETTLE_CYCLES - 1);

  logic [14:0]     sync1_q, sync2_q, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     digits_q, digits_d;
  logic [7:0]      blank_q, blank_d;
  logic [7:0]      invalid_q, invalid_d;
  logic [7:0]      seen_q, seen_d;
  logic            frame_q, frame_d;
  logic            err_q, err_d;

  logic            stable;
  logic            strobe;
  logic [7:0]      act;
  logic [6:0]      seg;
  logic            one_hot;
  logic            multi;
  logic            glyph_hit;
  logic [3:0]      glyph_val;

  // Inverse of the display controller's glyph table, segments in {g..a} order.
  always_comb begin
    glyph_hit = 1'b1;
    glyph_val = 4'h0;
    unique case (seg)
      7'h3F: glyph_val = 4'h0;
      7'h06: glyph_val = 4'h1;
      7'h5B: glyph_val = 4'h2;
      7'h4F: glyph_val = 4'h3;
      7'h66: glyph_val = 4'h4;
      7'h6D: glyph_val = 4'h5;
      7'h7D: glyph_val = 4'h6;
      7'h07: glyph_val = 4'h7;
      7'h7F: glyph_val = 4'h8;
      7'h6F: glyph_val = 4'h9;
      7'h77: glyph_val = 4'hA;
      7'h7C: glyph_val = 4'hB;
      7'h39: glyph_val = 4'hC;
      7'h5E: glyph_val = 4'hD;
      7'h79: glyph_val = 4'hE;
      7'h71: glyph_val = 4'hF;
      default: glyph_hit = 1'b0;
    endcase
  end

  assign stable  = (sync2_q == prev_q);
  // Saturation keeps the counter from revisiting the strobe value during a long dwell.
  assign strobe  = stable && (cnt_q == CntStrobe);
  assign act     = ~sync2_q[14:7];
  assign seg     = ~sync2_q[6:0];
  assign one_hot = (act != 8'h00) && ((act & (act - 8'd1)) == 8'h00);
  assign multi   = (act != 8'h00) && !one_hot;

  always_comb begin
    cnt_d = cnt_q;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    digits_d  = digits_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    seen_d    = seen_q;
    frame_d   = 1'b0;
    err_d     = err_q;
    if (err_clr_in) begin
      err_d = 1'b0;
    end
    if (strobe && multi) begin
      err_d = 1'b1;
    end
    if (strobe && one_hot) begin
      for (int i = 0; i < 8; i++) begin
        if (act[i]) begin
          digits_d[4*i +: 4] = glyph_hit ? glyph_val : 4'h0;
          blank_d[i]         = (seg == 7'h00);
          invalid_d[i]       = !glyph_hit && (seg != 7'h00);
        end
      end
      if ((seen_q | act) == 8'hFF) begin
        frame_d = 1'b1;
        seen_d  = 8'h00;
      end else begin
        seen_d = seen_q | act;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      cnt_q     <= '0;
      digits_q  <= '0;
      blank_q   <= '0;
      invalid_q <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= {an_in, cat_in};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign digits_out      = digits_q;
  assign blank_out       = blank_q;
  assign invalid_out     = invalid_q;
  assign frame_valid_out = frame_q;
  assign error_out       = err_q;

endmodule

// File: tb/tb_ssc_reader.sv
// Bench for ssc_reader: directed and random dwells on the display lines, checked against a
// dwell-length model of digit capture, frame completion and the error flag.
module tb_ssc_reader;

  localparam int S = 4;
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk;
  logic        rst_n;
  logic [6:0]  cat_i;
  logic [7:0]  an_i;
  logic        err_clr;
  logic [31:0] digits_out;
  logic [7:0]  blank_out;
  logic [7:0]  invalid_out;
  logic        frame_valid_out;
  logic        error_out;

  ssc_reader #(.SETTLE_CYCLES(S)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .cat_in          (cat_i),
    .an_in           (an_i),
    .err_clr_in      (err_clr),
    .digits_out      (digits_out),
    .blank_out       (blank_out),
    .invalid_out     (invalid_out),
    .frame_valid_out (frame_valid_out),
    .error_out       (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;

  always @(negedge clk) if (frame_valid_out === 1'b1) pulses++;

  // Reference state
  logic [3:0]  m_dig [8];
  logic [7:0]  m_blank, m_inv, m_seen;
  logic        m_err;
  int          m_frames = 0;
  logic [14:0] last_pat;
  int          run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_blank  = 8'h00;
    m_inv    = 8'h00;
    m_seen   = 8'h00;
    m_err    = 1'b0;
    last_pat = 15'h7FFF;
    run      = 1000;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) exp_d[4*i +: 4] = m_dig[i];
    chk({tag, ".digits"}, digits_out, exp_d);
    chk({tag, ".blank"}, {24'h0, blank_out}, {24'h0, m_blank});
    chk({tag, ".invalid"}, {24'h0, invalid_out}, {24'h0, m_inv});
    chk({tag, ".error"}, {31'h0, error_out}, {31'h0, m_err});
    chk({tag, ".frames"}, pulses, m_frames);
  endtask

  // A dwell is captured once the same pattern has been held S+1 cycles; the capture lands
  // at edge S+3 counted from the first cycle of that pattern.
  task automatic model_step(input logic [7:0] an, input logic [6:0] cat, input int n,
                            input int clr_at);
    logic [14:0] pat;
    logic [7:0]  a;
    logic [6:0]  s;
    int          old, e, v;
    bit          clr, hit;
    pat = {an, cat};
    old = (pat == last_pat) ? run : 0;
    clr = (clr_at >= 0) && (clr_at < n);
    a   = ~an;
    s   = ~cat;
    if (old < S + 1 && old + n >= S + 1) begin
      e = S + 3 - old;
      if ($countones(a) >= 2) begin
        m_err = (clr && (clr_at + 1 > e)) ? 1'b0 : 1'b1;
      end else begin
        if (clr) m_err = 1'b0;
        if (a != 8'h00) begin
          hit = 0;
          v   = 0;
          for (int g = 0; g < 16; g++) if (GLY[g] == s) begin hit = 1; v = g; end
          for (int i = 0; i < 8; i++) if (a[i]) begin
            m_dig[i]   = hit ? 4'(v) : 4'h0;
            m_blank[i] = (s == 7'h00);
            m_inv[i]   = !hit && (s != 7'h00);
          end
          m_seen = m_seen | a;
          if (m_seen == 8'hFF) begin
            m_frames++;
            m_seen = 8'h00;
          end
        end
      end
    end else if (clr) begin
      m_err = 1'b0;
    end
    last_pat = pat;
    run      = (old + n > 1000) ? 1000 : old + n;
  endtask

  // Everything from earlier steps has landed by edge 2 of the next step.
  task automatic step(input logic [7:0] an, input logic [6:0] cat, input int n,
                      input int clr_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (k == 2) check_all("step");
      an_i    = an;
      cat_i   = cat;
      err_clr = (k == clr_at);
    end
    model_step(an, cat, n, clr_at);
  endtask

  task automatic digit(input int idx, input logic [6:0] seg, input int n);
    step(~(8'h01 << idx), ~seg, n, -1);
  endtask

  task automatic do_reset();
    step(8'hFF, 7'h7F, 4, -1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    an_i  = 8'hFF;
    cat_i = 7'h7F;
    model_reset();
    #2;
    check_all("in_reset");
    repeat (3) @(negedge clk);
    #1;
    check_all("held_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    logic [6:0] c;
    int         n, clr_at, sel;
    rst_n   = 1'b0;
    an_i    = 8'hFF;
    cat_i   = 7'h7F;
    err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame resembling the loopback image: r,C,blank,3,0,blank,5,A
    digit(0, 7'h50, 5);
    digit(1, GLY[12], 5);
    digit(2, 7'h00, 5);
    digit(3, GLY[3], 5);
    digit(4, GLY[0], 5);
    digit(5, 7'h00, 5);
    digit(6, GLY[5], 5);
    digit(7, GLY[10], 6);
    step(8'hFF, 7'h7F, 5, -1);

    // Dwell of S cycles is dropped, S+1 is captured
    digit(3, GLY[8], 4);
    digit(3, GLY[1], 3);
    digit(3, GLY[8], 5);
    step(8'hFF, 7'h7F, 5, -1);

    // Multi-digit error, clear, clear coincident with a new error, clear again
    step(~8'h03, ~GLY[2], 10, -1);
    step(8'hFF, 7'h7F, 5, 3);
    step(~8'h03, ~GLY[4], 10, S + 2);
    step(8'hFF, 7'h7F, 5, -1);
    step(8'hFF, 7'h7F, 5, 3);

    // Recapturing digit 0 mid-frame does not complete the frame early
    for (int i = 0; i < 7; i++) digit(i, GLY[i + 7], 5);
    digit(0, GLY[1], 5);
    digit(7, GLY[15], 5);
    step(8'hFF, 7'h7F, 5, -1);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) digit(i, GLY[i], 6);
    do_reset();
    for (int i = 7; i >= 0; i--) digit(i, GLY[15 - i], 5);
    step(8'hFF, 7'h7F, 20, -1);

    for (int t = 0; t < 150; t++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70) begin
        a = 8'h01 << $urandom_range(0, 7);
      end else if (sel < 85) begin
        a = 8'h00;
      end else begin
        n = int'($urandom_range(0, 7));
        a = 8'($urandom) | (8'h01 << n) | (8'h01 << ((n + 1) % 8));
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       c = GLY[$urandom_range(0, 15)];
      else if (sel == 7) c = 7'h00;
      else               c = 7'($urandom);
      n      = int'($urandom_range(3, 8));
      clr_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, n - 1)) : -1;
      if ($urandom_range(0, 9) == 0) begin
        step(last_pat[14:7], last_pat[6:0], n, clr_at);
      end else begin
        step(~a, ~c, n, clr_at);
      end
    end
    step(8'hFF, 7'h7F, 6, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
